// File: rtl/spi2apb_bridge_if.sv
// APB bus between the SPI bridge (master) and a peripheral (slave).
//   psel, penable, paddr, pwrite, pwdata : master -> slave
//   prdata, pready, pslverr              : slave  -> master
interface spi2apb_bridge_if;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/spi2apb_bridge.sv
// SPI (mode 0) slave that turns host frames into single APB read/write transfers.
// Frame: cmd byte {wr, idx[6:0]}; write = cmd + 4 data bytes, read = cmd + dummy
// byte + 4 data bytes returned on miso. paddr = BASEADDR | {idx, 2'b00}.
// Ports:
//   clk, rstn            system clock, async active-low reset
//   sck, mosi, csn       SPI inputs, oversampled through SYNC_STAGES flops
//   miso, miso_oe        SPI output and its enable (enable while csn low)
//   busy                 high from csn fall until the FSM returns to idle
//   err                  sticky pslverr/timeout flag, cleared at next csn fall
//   apb                  APB master modport (spi2apb_bridge_if)
// Optional: define SPI2APB_STATUS_EN to shift {6'b0, timeout_seen, err} of the
// previous frame out on miso during the cmd byte.
module spi2apb_bridge #(
    parameter logic [31:0] BASEADDR    = 32'h0000_0000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sck,
    input  logic             mosi,
    input  logic             csn,
    output logic             miso,
    output logic             miso_oe,
    output logic             busy,
    output logic             err,
    spi2apb_bridge_if.master apb
);
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 6;
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [DW-1:0] TMO_DATA = 32'hDEAD_DEAD;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WDATA, S_SETUP, S_ACCESS, S_RDATA, S_WAIT_CS
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, csn_sync_q;
    logic                   sck_prev_q, csn_prev_q;
    logic                   sck_s, mosi_s, csn_s;
    logic                   sck_rise, sck_fall, csn_fall;
    logic [BW-1:0]          bit_cnt_q;
    logic [3:0]             dummy_q;
    logic                   dummy_done;
    logic [TW-1:0]          tmo_cnt_q;
    logic                   tmo_hit;
    logic [DW-2:0]          rx_q;
    logic [DW-1:0]          tx_q;
    logic                   miso_q, miso_oe_q, busy_q, err_q;
    logic                   psel_q, penable_q, pwrite_q;
    logic [DW-1:0]          paddr_q, pwdata_q;
`ifdef SPI2APB_STATUS_EN
    logic                   tmo_seen_q;
    logic [7:0]             status_c;
    assign status_c = {6'b0, tmo_seen_q, err_q};
`endif

    // Input synchronizers plus previous-value flops for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '1;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
            sck_prev_q  <= sck_s;
            csn_prev_q  <= csn_s;
        end
    end

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s      = csn_sync_q[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_fall   = ~sck_s & sck_prev_q;
    assign csn_fall   = ~csn_s & csn_prev_q;
    assign dummy_done = (dummy_q == 4'd8);
    assign tmo_hit    = (tmo_cnt_q == TW'(TIMEOUT - 1));

    // Next-state logic; once the APB transfer has started it always completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (csn_fall) state_d = S_CMD;
            S_CMD: begin
                if (csn_s) state_d = S_IDLE;
                else if (sck_rise && bit_cnt_q == BW'(7)) state_d = rx_q[6] ? S_WDATA : S_SETUP;
            end
            S_WDATA: begin
                if (csn_s) state_d = S_IDLE;
                else if (sck_rise && bit_cnt_q == BW'(31)) state_d = S_SETUP;
            end
            S_SETUP:   state_d = S_ACCESS;
            S_ACCESS: begin
                if (apb.pready || tmo_hit) begin
                    if (csn_s)         state_d = S_IDLE;
                    else if (pwrite_q) state_d = S_WAIT_CS;
                    else               state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (csn_s) state_d = S_IDLE;
                else if (sck_rise && dummy_done && bit_cnt_q == BW'(31)) state_d = S_WAIT_CS;
            end
            S_WAIT_CS: if (csn_s) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State register, counters, shift registers and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            dummy_q    <= '0;
            tmo_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
`ifdef SPI2APB_STATUS_EN
            tmo_seen_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            miso_oe_q <= ~csn_s;
            busy_q    <= (state_d != S_IDLE);
            psel_q    <= (state_d == S_SETUP) || (state_d == S_ACCESS);
            penable_q <= (state_d == S_ACCESS);

            if (sck_rise) rx_q <= {rx_q[DW-3:0], mosi_s};

            if (state_d != state_q) begin
                bit_cnt_q <= '0;
            end else if (sck_rise && (state_q == S_CMD || state_q == S_WDATA ||
                                      (state_q == S_RDATA && dummy_done))) begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
            end

            // Dummy-byte rises are counted across SETUP/ACCESS/RDATA
            if (state_d == S_SETUP && state_q != S_SETUP) begin
                dummy_q <= '0;
            end else if (sck_rise && !dummy_done &&
                         (state_q == S_SETUP || state_q == S_ACCESS || state_q == S_RDATA)) begin
                dummy_q <= dummy_q + 4'd1;
            end

            if (state_q == S_ACCESS && state_d == S_ACCESS) tmo_cnt_q <= tmo_cnt_q + TW'(1);
            else                                            tmo_cnt_q <= '0;

            case (state_q)
                S_IDLE: begin
                    miso_q <= 1'b0;
                    if (csn_fall) begin
                        err_q <= 1'b0;
`ifdef SPI2APB_STATUS_EN
                        miso_q     <= status_c[7];
                        tx_q       <= {status_c[6:0], 25'd0};
                        tmo_seen_q <= 1'b0;
`endif
                    end
                end
                S_CMD: begin
                    if (sck_rise && bit_cnt_q == BW'(7)) begin
                        pwrite_q <= rx_q[6];
                        paddr_q  <= BASEADDR | {23'd0, rx_q[5:0], mosi_s, 2'b00};
                    end
`ifdef SPI2APB_STATUS_EN
                    if (sck_fall) begin
                        miso_q <= tx_q[DW-1];
                        tx_q   <= {tx_q[DW-2:0], 1'b0};
                    end
`else
                    miso_q <= 1'b0;
`endif
                end
                S_WDATA: begin
                    miso_q <= 1'b0;
                    if (sck_rise && bit_cnt_q == BW'(31)) pwdata_q <= {rx_q, mosi_s};
                end
                S_ACCESS: begin
                    miso_q <= 1'b0;
                    if (apb.pready) begin
                        tx_q <= apb.prdata;
                        if (apb.pslverr) err_q <= 1'b1;
                    end else if (tmo_hit) begin
                        tx_q  <= TMO_DATA;
                        err_q <= 1'b1;
`ifdef SPI2APB_STATUS_EN
                        tmo_seen_q <= 1'b1;
`endif
                    end
                end
                S_RDATA: begin
                    // First data bit goes out on the fall that ends the dummy byte
                    if (sck_fall && dummy_done) begin
                        miso_q <= tx_q[DW-1];
                        tx_q   <= {tx_q[DW-2:0], 1'b0};
                    end
                end
                default: miso_q <= 1'b0;
            endcase
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
endmodule

// File: tb/tb_spi2apb_bridge.sv
// Bench for spi2apb_bridge: SPI host tasks, an APB slave model with programmable
// wait states / error / no-response, and queues of expected APB transfers and
// expected miso read words.
module tb_spi2apb_bridge;
    localparam int unsigned HALF = 8;
    localparam int unsigned SYNC = 2;
`ifdef SPI2APB_STATUS_EN
    localparam logic [7:0] STAT_AFTER_TMO = 8'h03;
`else
    localparam logic [7:0] STAT_AFTER_TMO = 8'h00;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } txn_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic sck  = 1'b0;
    logic mosi = 1'b0;
    logic csn  = 1'b1;
    logic miso, miso_oe, busy, err;

    spi2apb_bridge_if apb();

    spi2apb_bridge #(
        .BASEADDR   (32'h0000_0000),
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (16)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .sck    (sck),
        .mosi   (mosi),
        .csn    (csn),
        .miso   (miso),
        .miso_oe(miso_oe),
        .busy   (busy),
        .err    (err),
        .apb    (apb)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    txn_t        exp_q[$];
    txn_t        obs_q[$];
    logic [31:0] rd_exp_q[$];

    int          slv_wait  = 0;
    bit          slv_never = 1'b0;
    bit          slv_err   = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          acc_n     = 0;
    int          psel_cyc  = 0;
    int          pen_cyc   = 0;
    int          n_setup   = 0;

    // APB slave model and bus monitor
    always @(negedge clk) begin
        txn_t t;
        if (apb.psel && apb.penable) begin
            apb.pready  = !slv_never && (acc_n >= slv_wait);
            apb.pslverr = apb.pready && slv_err;
            apb.prdata  = apb.pready ? slv_rdata : 32'h0;
            acc_n++;
            if (apb.pready) begin
                t.addr = apb.paddr;
                t.wr   = apb.pwrite;
                t.data = apb.pwrite ? apb.pwdata : slv_rdata;
                obs_q.push_back(t);
            end
        end else begin
            apb.pready  = 1'b0;
            apb.pslverr = 1'b0;
            apb.prdata  = 32'h0;
            acc_n       = 0;
        end
        if (apb.psel)                 psel_cyc++;
        if (apb.penable)              pen_cyc++;
        if (apb.psel && !apb.penable) n_setup++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic mon_clear(input int w, input bit never, input bit e, input logic [31:0] rd);
        slv_wait  = w;
        slv_never = never;
        slv_err   = e;
        slv_rdata = rd;
        psel_cyc  = 0;
        pen_cyc   = 0;
        n_setup   = 0;
        obs_q.delete();
        exp_q.delete();
        rd_exp_q.delete();
    endtask

    // Mode-0 host: drive mosi while sck low, sample miso at the rising edge
    task automatic spi_xfer(input int nbits, input logic [63:0] tx, output logic [63:0] rx);
        rx  = '0;
        csn = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            rx  = {rx[62:0], miso};
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic spi_end();
        repeat (HALF) @(negedge clk);
        csn = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({miso, miso_oe, busy, err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_spi_outs got=%b exp=0000", {miso, miso_oe, busy, err});
        end
        checks++;
        if ({apb.psel, apb.penable, apb.pwrite} !== 3'b0) begin
            failures++;
            $display("FAIL reset_apb_ctrl got=%b exp=000", {apb.psel, apb.penable, apb.pwrite});
        end
        checks++;
        if (apb.paddr !== 32'h0 || apb.pwdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_apb_data got paddr=%h pwdata=%h exp 0", apb.paddr, apb.pwdata);
        end
        rstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        logic [63:0] rx;
        txn_t        e, o;
        mon_clear(0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back('{addr: 32'h4, wr: 1'b1, data: 32'h0000_00A5});
        spi_xfer(40, {24'd0, 8'h81, 32'h0000_00A5}, rx);
        checks++;
        if (busy !== 1'b1 || miso_oe !== 1'b1) begin
            failures++;
            $display("FAIL write_busy_oe got busy=%b oe=%b exp 1 1", busy, miso_oe);
        end
        spi_end();
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL write_txn_count got=%0d exp=1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL write_txn got %h/%b/%h exp %h/%b/%h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
            end
        end
        checks++;
        if (psel_cyc != 2 || pen_cyc != 1) begin
            failures++;
            $display("FAIL write_psel_len got psel=%0d pen=%0d exp 2 1", psel_cyc, pen_cyc);
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL write_err_busy got err=%b busy=%b exp 0 0", err, busy);
        end
    endtask

    task automatic test_read();
        logic [63:0] rx;
        logic [31:0] re;
        txn_t        e, o;
        mon_clear(0, 1'b0, 1'b0, 32'h1234_5678);
        exp_q.push_back('{addr: 32'h0, wr: 1'b0, data: 32'h1234_5678});
        rd_exp_q.push_back(32'h1234_5678);
        spi_xfer(48, {16'd0, 8'h00, 40'd0}, rx);
        spi_end();
        re = rd_exp_q.pop_front();
        checks++;
        if (rx[31:0] !== re) begin
            failures++;
            $display("FAIL read_miso got=%h exp=%h", rx[31:0], re);
        end
        checks++;
        if (rx[47:32] !== 16'h0) begin
            failures++;
            $display("FAIL read_cmd_dummy_miso got=%h exp=0000", rx[47:32]);
        end
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL read_txn_count got=%0d exp=1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL read_txn got %h/%b/%h exp %h/%b/%h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL read_err got=%b exp=0", err);
        end
    endtask

    task automatic test_wait_states();
        logic [63:0] rx;
        txn_t        e, o;
        mon_clear(3, 1'b0, 1'b0, 32'h0);
        exp_q.push_back('{addr: 32'h14, wr: 1'b1, data: 32'hCAFE_F00D});
        spi_xfer(40, {24'd0, 8'h85, 32'hCAFE_F00D}, rx);
        spi_end();
        checks++;
        if (pen_cyc != 4 || psel_cyc != 5) begin
            failures++;
            $display("FAIL wait_penable_len got pen=%0d psel=%0d exp 4 5", pen_cyc, psel_cyc);
        end
        checks++;
        if (n_setup != 1 || obs_q.size() != 1) begin
            failures++;
            $display("FAIL wait_single_txn got setups=%0d done=%0d exp 1 1", n_setup, obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL wait_txn got %h/%b/%h exp %h/%b/%h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
            end
        end
    endtask

    task automatic test_timeout();
        logic [63:0] rx;
        logic [31:0] re;
        mon_clear(0, 1'b1, 1'b0, 32'h5555_5555);
        rd_exp_q.push_back(32'hDEAD_DEAD);
        spi_xfer(48, {16'd0, 8'h10, 40'd0}, rx);
        spi_end();
        re = rd_exp_q.pop_front();
        checks++;
        if (pen_cyc != 16 || n_setup != 1) begin
            failures++;
            $display("FAIL timeout_access_len got pen=%0d setups=%0d exp 16 1", pen_cyc, n_setup);
        end
        checks++;
        if (apb.paddr !== 32'h40 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_addr_done got paddr=%h done=%0d exp 40 0", apb.paddr, obs_q.size());
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_err got=%b exp=1", err);
        end
        checks++;
        if (rx[31:0] !== re) begin
            failures++;
            $display("FAIL timeout_miso got=%h exp=%h", rx[31:0], re);
        end
    endtask

    task automatic test_err_clear_status();
        logic [63:0] rx;
        txn_t        e, o;
        mon_clear(0, 1'b0, 1'b0, 32'h0BAD_F00D);
        exp_q.push_back('{addr: 32'h4, wr: 1'b0, data: 32'h0BAD_F00D});
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL sticky_err got=%b exp=1", err);
        end
        spi_xfer(48, {16'd0, 8'h01, 40'd0}, rx);
        checks++;
        if (rx[47:40] !== STAT_AFTER_TMO) begin
            failures++;
            $display("FAIL status_byte got=%h exp=%h", rx[47:40], STAT_AFTER_TMO);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared got=%b exp=0", err);
        end
        spi_end();
        checks++;
        if (rx[31:0] !== 32'h0BAD_F00D || obs_q.size() != 1) begin
            failures++;
            $display("FAIL clear_read got data=%h done=%0d exp 0bad_f00d 1", rx[31:0], obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL clear_txn got %h/%b/%h exp %h/%b/%h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
            end
        end
    endtask

    task automatic test_abort();
        logic [63:0] rx;
        int          n;
        mon_clear(0, 1'b0, 1'b0, 32'h0);
        spi_xfer(28, {36'd0, 8'h81, 20'hABCDE}, rx);
        csn = 1'b1;
        n   = 0;
        while (busy !== 1'b0 && n < int'(SYNC + 2)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy got=%b exp=0 after %0d cycles", busy, n);
        end
        repeat (4 * HALF) @(negedge clk);
        checks++;
        if (n_setup != 0 || psel_cyc != 0) begin
            failures++;
            $display("FAIL abort_no_psel got setups=%0d psel=%0d exp 0 0", n_setup, psel_cyc);
        end
        checks++;
        if (miso_oe !== 1'b0) begin
            failures++;
            $display("FAIL abort_oe got=%b exp=0", miso_oe);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rx;
        logic [31:0] re;
        txn_t        e, o;
        mon_clear(0, 1'b0, 1'b1, 32'h0);
        exp_q.push_back('{addr: 32'h1FC, wr: 1'b1, data: 32'h8000_0001});
        spi_xfer(40, {24'd0, 8'hFF, 32'h8000_0001}, rx);
        spi_end();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pslverr_write got=%b exp=1", err);
        end

        slv_rdata = 32'hA5A5_5A5A;
        exp_q.push_back('{addr: 32'h88, wr: 1'b0, data: 32'hA5A5_5A5A});
        rd_exp_q.push_back(32'hA5A5_5A5A);
        spi_xfer(48, {16'd0, 8'h22, 40'd0}, rx);
        spi_end();
        re = rd_exp_q.pop_front();
        checks++;
        if (rx[31:0] !== re || err !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pslverr_read got data=%h err=%b exp %h 1", rx[31:0], err, re);
        end

        slv_err  = 1'b0;
        slv_wait = 1;
        exp_q.push_back('{addr: 32'hC, wr: 1'b1, data: 32'h0000_0001});
        spi_xfer(40, {24'd0, 8'h83, 32'h0000_0001}, rx);
        spi_end();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_clean_err got=%b exp=0", err);
        end

        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_txn_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_txn got %h/%b/%h exp %h/%b/%h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_timeout();
        test_err_clear_status();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
